// File: rtl/cache_wb_pkg.sv
// Shared types and constants for the cache write-back buffer.
// Entries are word-aligned RAM writes waiting to drain.
package cache_wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WORD_OFFSET   = 2;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_addr_match.sv
// Word-address compare of one address against every buffer entry.
// Returns a one-hot match vector and the matching entry's data (0 on no match).
module wb_addr_match
  import cache_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic [WB_ADDR_WIDTH-1:0] addr,
  input  wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         match,
  output logic [WB_DATA_WIDTH-1:0] data
);

  always_comb begin
    match = '0;
    data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = entries[i].valid &&
                 ((entries[i].addr >> WORD_OFFSET) == (addr >> WORD_OFFSET));
      // Coalescing keeps at most one hit, so OR-ing acts as a mux.
      if (match[i]) data = data | entries[i].data;
    end
  end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer between the cache controller and RAM: queues dirty evictions,
// coalesces repeat writes to the same word, drains in order and forwards to misses.
module cache_writeback_buffer
  import cache_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int RAM_ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int PTR_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid,
  input  logic [RAM_ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0]     push_data,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic [RAM_ADDR_WIDTH-1:0] lookup_addr,
  output logic                      lookup_hit,
  output logic [DATA_WIDTH-1:0]     lookup_data,
  input  logic                      miss_pending,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wd,
  input  logic                      ram_ready
);

  logic                      valid_q [DEPTH];
  logic [RAM_ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q  [DEPTH];
  logic [PTR_WIDTH-1:0]      head_ptr, tail_ptr;
  logic [PTR_WIDTH:0]        count_q, count_next;
  logic                      empty_q, full_q, overflow_q;

  wb_entry_t                 entries [DEPTH];
  logic [DEPTH-1:0]          push_match, lookup_match_unused;
  logic [DATA_WIDTH-1:0]     push_data_unused;
  logic                      pop, coalesce, alloc_req, alloc;
  logic [RAM_ADDR_WIDTH-1:0] push_addr_aligned;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = valid_q[i];
      entries[i].addr  = addr_q[i];
      entries[i].data  = data_q[i];
    end
  end

  wb_addr_match #(.DEPTH(DEPTH)) u_push_match (
    .addr    (push_addr),
    .entries (entries),
    .match   (push_match),
    .data    (push_data_unused)
  );

  wb_addr_match #(.DEPTH(DEPTH)) u_lookup_match (
    .addr    (lookup_addr),
    .entries (entries),
    .match   (lookup_match_unused),
    .data    (lookup_data)
  );

  assign lookup_hit = |lookup_match_unused;

  assign ram_we   = !empty_q && !miss_pending;
  assign ram_addr = empty_q ? '0 : addr_q[head_ptr];
  assign ram_wd   = empty_q ? '0 : data_q[head_ptr];
  assign pop      = ram_we && ram_ready;

  // A hit on the head that is leaving this cycle must re-allocate so the newer
  // data is written after the older one instead of being lost with the pop.
  assign coalesce          = push_valid && (|push_match) && !(pop && push_match[head_ptr]);
  assign alloc_req         = push_valid && !coalesce;
  assign alloc             = alloc_req && (!full_q || pop);
  assign push_addr_aligned = {push_addr[RAM_ADDR_WIDTH-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}};

  always_comb begin
    count_next = count_q;
    case ({alloc, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Control state: pointers, occupancy, flags and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + 1'b1;
      end
      // When full, tail == head: the allocate must win over the pop clear.
      if (alloc) begin
        valid_q[tail_ptr] <= 1'b1;
        tail_ptr          <= tail_ptr + 1'b1;
      end
      if (alloc_req && !alloc) overflow_q <= 1'b1;
      count_q <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == (PTR_WIDTH+1)'(DEPTH));
    end
  end

  // Entry payload: no reset, qualified by the valid bits
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && (tail_ptr == PTR_WIDTH'(i))) begin
        addr_q[i] <= push_addr_aligned;
        data_q[i] <= push_data;
      end else if (coalesce && push_match[i]) begin
        data_q[i] <= push_data;
      end
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Scoreboard bench for cache_writeback_buffer: a queue-based reference model predicts
// flags, lookups and the ordered RAM write stream; a negedge monitor compares.
module tb_cache_writeback_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          full, empty, overflow;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic          miss_pending;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic          ram_ready;

  always #5 clk = ~clk;

  cache_writeback_buffer #(
    .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty), .overflow(overflow),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .miss_pending(miss_pending),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_ready(ram_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];   // model contents, oldest first
  ent_t          sb[$];   // expected RAM writes, in order
  bit            m_ovf;
  bit            chk_en;
  int            cmp_cnt = 0;
  int            err_cnt = 0;

  logic          exp_empty, exp_full, exp_ovf, exp_we, exp_hit;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_ld;

  function automatic logic [AW-1:0] wa(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model predicts this cycle's outputs, then
  // advances itself to the state after the coming edge.
  task automatic cycle(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit mp, input bit rr, input logic [AW-1:0] la);
    int idx;
    bit pop, app;
    ent_t e;
    @(posedge clk); #1;
    push_valid = pv; push_addr = pa; push_data = pd;
    miss_pending = mp; ram_ready = rr; lookup_addr = la;
    exp_empty = (mq.size() == 0);
    exp_full  = (mq.size() == DEPTH);
    exp_ovf   = m_ovf;
    exp_we    = !exp_empty && !mp;
    exp_addr  = exp_empty ? '0 : mq[0].addr;
    exp_wd    = exp_empty ? '0 : mq[0].data;
    exp_hit   = 1'b0;
    exp_ld    = '0;
    foreach (mq[i]) if (mq[i].addr == wa(la)) begin exp_hit = 1'b1; exp_ld = mq[i].data; end
    chk_en = 1'b1;
    pop = exp_we && rr;
    if (pop) sb.push_back(mq[0]);
    app = 1'b0;
    if (pv) begin
      idx = -1;
      foreach (mq[i]) if (mq[i].addr == wa(pa)) idx = i;
      if (idx >= 0 && !(idx == 0 && pop)) mq[idx].data = pd;
      else if (mq.size() < DEPTH || pop) app = 1'b1;
      else m_ovf = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (app) begin
      e.addr = wa(pa);
      e.data = pd;
      mq.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit mp, input bit rr);
    repeat (n) cycle(1'b0, '0, '0, mp, rr, 32'h100 + 32'($urandom_range(0, 3) * 4));
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    chk_en = 1'b0;
    mq.delete(); sb.delete(); m_ovf = 1'b0;
    push_valid = 1'b0;
    #1;
    chk("rst_async_ram_we", ram_we, 0);
    chk("rst_async_empty", empty, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_lookup_hit", lookup_hit, 0);
    chk("rst_lookup_data", lookup_data, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  // Monitor: compares every cycle's outputs and consumes the expected write stream.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("empty", empty, exp_empty);
      chk("full", full, exp_full);
      chk("overflow", overflow, exp_ovf);
      chk("ram_we", ram_we, exp_we);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_wd", ram_wd, exp_wd);
      chk("lookup_hit", lookup_hit, exp_hit);
      chk("lookup_data", lookup_data, exp_ld);
      if (ram_we && ram_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_write", ram_addr, 32'hFFFF_FFFF);
        end else begin
          chk("sb_write_addr", ram_addr, sb[0].addr);
          chk("sb_write_data", ram_wd, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; chk_en = 1'b0; m_ovf = 1'b0;
    push_valid = 1'b0; push_addr = '0; push_data = '0;
    miss_pending = 1'b0; ram_ready = 1'b0; lookup_addr = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("init_empty", empty, 1);
    chk("init_full", full, 0);
    chk("init_ram_we", ram_we, 0);
    chk("init_lookup_hit", lookup_hit, 0);

    // Single push drains on the next cycle
    idle(2, 0, 1);
    cycle(1, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0);
    idle(3, 0, 1);

    // Fill under miss_pending, overflow on the fifth, then ordered drain
    cycle(1, 32'h10, 32'hA000_0010, 1, 1, 32'h10);
    cycle(1, 32'h20, 32'hA000_0020, 1, 1, 32'h10);
    cycle(1, 32'h30, 32'hA000_0030, 1, 1, 32'h20);
    cycle(1, 32'h40, 32'hA000_0040, 1, 1, 32'h30);
    cycle(1, 32'h50, 32'hA000_0050, 1, 1, 32'h40);
    idle(2, 1, 1);
    idle(6, 0, 1);

    // Coalesce two writes to one word
    do_reset();
    cycle(1, 32'h200, 32'h1111, 1, 1, 32'h200);
    cycle(1, 32'h200, 32'h2222, 1, 1, 32'h200);
    idle(2, 1, 1);
    idle(3, 0, 1);

    // Forwarding ignores the byte offset
    cycle(1, 32'h300, 32'hCAFE_0001, 1, 1, 32'h0);
    cycle(0, 0, 0, 1, 1, 32'h302);
    cycle(0, 0, 0, 1, 1, 32'h304);
    idle(3, 0, 1);

    // Push and pop in the same cycle while full; pointers wrap
    do_reset();
    cycle(1, 32'h600, 32'h0600, 1, 1, 32'h0);
    cycle(1, 32'h610, 32'h0610, 1, 1, 32'h0);
    cycle(1, 32'h620, 32'h0620, 1, 1, 32'h0);
    cycle(1, 32'h630, 32'h0630, 1, 1, 32'h0);
    cycle(1, 32'h500, 32'h0500, 0, 1, 32'h600);
    cycle(0, 0, 0, 1, 1, 32'h500);
    idle(6, 0, 1);

    // Head hit while the head is popping re-allocates behind it
    cycle(1, 32'h700, 32'h7001, 1, 1, 32'h0);
    cycle(1, 32'h700, 32'h7002, 0, 1, 32'h700);
    idle(4, 0, 1);

    // Reset while a write is pending with no accept
    cycle(1, 32'h800, 32'h8001, 1, 0, 32'h0);
    cycle(1, 32'h804, 32'h8002, 1, 0, 32'h0);
    cycle(1, 32'h808, 32'h8003, 1, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h804);
    do_reset();
    idle(5, 0, 1);

    // Randomized traffic over a small address pool to force coalescing and hits
    for (int seg = 0; seg < 12; seg++) begin
      int mp_pct;
      mp_pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 30 : 5);
      for (int n = 0; n < 120; n++) begin
        logic [AW-1:0] pa, la;
        pa = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        la = 32'h1000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
        cycle(bit'($urandom_range(0, 1)), pa, $urandom,
              ($urandom_range(0, 99) < mp_pct), ($urandom_range(0, 3) != 0), la);
      end
      if (seg == 5) do_reset();
    end

    idle(12, 0, 1);
    chk("sb_leftover", sb.size(), 0);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
